// File: rtl/wb_pkg.sv
// Shared types for the writeback arbiter: arbitration state and register index.
// No logic; no latency.
// No flow control.
package wb_pkg;

  localparam int WB_REG_COUNT_DFLT = 32;

  // Arbitration state: NORMAL lets the ALU win, DRAIN forces one queue pop.
  typedef enum logic {
    NORMAL = 1'b0,
    DRAIN  = 1'b1
  } wb_state_e;

  // Register index at the default register count.
  typedef logic [$clog2(WB_REG_COUNT_DFLT)-1:0] reg_idx_t;

  // Index width for an arbitrary register count. At least one bit wide.
  function automatic int idx_width(input int count);
    return (count > 1) ? $clog2(count) : 1;
  endfunction

endpackage

// File: rtl/wb_result_fifo.sv
// Generic circular FIFO holding long-latency results until they win the write port.
// Latency: a pushed entry is visible at head one cycle after the push.
// Backpressure: push_ready = !full. A push while full is refused even if a pop happens in the same cycle.
//
// Ports: clk, rst (sync, active-high); push_valid/push_ready/push_data;
//        pop, empty, head (data at the read pointer, valid when !empty).
module wb_result_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_valid,
  output logic             push_ready,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             empty,
  output logic [WIDTH-1:0] head
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr, wr_nxt, rd_nxt;
  logic             full_q, empty_q;
  logic             do_push, do_pop;

  assign do_push = push_valid && !full_q;
  assign do_pop  = pop && !empty_q;
  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  assign wr_nxt  = wr_ptr + 1'b1;
  assign rd_nxt  = rd_ptr + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_nxt;
      if (do_pop)  rd_ptr <= rd_nxt;
      // Equal pointers are ambiguous, so full and empty are tracked as flags.
      // A simultaneous push and pop leaves occupancy unchanged.
      if (do_push && !do_pop) begin
        empty_q <= 1'b0;
        full_q  <= (wr_nxt == rd_ptr);
      end else if (do_pop && !do_push) begin
        full_q  <= 1'b0;
        empty_q <= (rd_nxt == wr_ptr);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign push_ready = !full_q;
  assign empty      = empty_q;
  assign head       = mem[rd_ptr];

endmodule

// File: rtl/wb_arbiter.sv
// Arbitrates one register-file write port between the ALU and a long-latency result queue.
// Latency: writeEnable/waddr/wdata are registered one cycle after the winner is selected.
// Backpressure: ll_ready = queue not full. alu_hold stalls the ALU for one DRAIN cycle after
//   STARVE_LIMIT consecutive ALU wins with the queue non-empty.
//
// Ports: clk, rst (sync, active-high); alu_valid/alu_rd/alu_data, alu_hold;
//        ll_valid/ll_ready/ll_rd/ll_data; iss_valid/iss_rd, q_rd/q_busy (scoreboard);
//        writeEnable/waddr/wdata (register file write port).
// Optional: define WB_SCOREBOARD_EN to build the pending-write scoreboard. Without it,
//   q_busy is 0 and the iss_* inputs are ignored.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int REG_WIDTH    = 64,
  parameter int REG_COUNT    = 32,
  parameter int LQ_DEPTH     = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         alu_valid,
  input  logic [idx_width(REG_COUNT)-1:0] alu_rd,
  input  logic [REG_WIDTH-1:0]         alu_data,
  output logic                         alu_hold,
  input  logic                         ll_valid,
  output logic                         ll_ready,
  input  logic [idx_width(REG_COUNT)-1:0] ll_rd,
  input  logic [REG_WIDTH-1:0]         ll_data,
  input  logic                         iss_valid,
  input  logic [idx_width(REG_COUNT)-1:0] iss_rd,
  input  logic [idx_width(REG_COUNT)-1:0] q_rd,
  output logic                         q_busy,
  output logic                         writeEnable,
  output logic [idx_width(REG_COUNT)-1:0] waddr,
  output logic [REG_WIDTH-1:0]         wdata
);
  localparam int IDX_W = idx_width(REG_COUNT);
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  wb_state_e             state, state_nxt;
  logic [CNT_W-1:0]      cnt, cnt_nxt;

  logic                  q_empty, q_pop;
  logic [IDX_W+REG_WIDTH-1:0] q_head;
  logic [IDX_W-1:0]      head_rd;
  logic [REG_WIDTH-1:0]  head_data;

  logic                  sel_vld;
  logic [IDX_W-1:0]      sel_rd;
  logic [REG_WIDTH-1:0]  sel_data;

  wb_result_fifo #(
    .DEPTH (LQ_DEPTH),
    .WIDTH (IDX_W + REG_WIDTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_valid (ll_valid),
    .push_ready (ll_ready),
    .push_data  ({ll_rd, ll_data}),
    .pop        (q_pop),
    .empty      (q_empty),
    .head       (q_head)
  );

  assign head_rd   = q_head[IDX_W+REG_WIDTH-1 -: IDX_W];
  assign head_data = q_head[REG_WIDTH-1:0];

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= NORMAL;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state logic. Only ALU wins over a waiting queue advance the starvation
  // count; a pop, an idle ALU or an empty queue clears it.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = '0;
    case (state)
      NORMAL: begin
        if (alu_valid && !q_empty) begin
          cnt_nxt = cnt + 1'b1;
          if (cnt == CNT_W'(STARVE_LIMIT - 1)) state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        state_nxt = NORMAL;
      end
      default: begin
        state_nxt = NORMAL;
      end
    endcase
  end

  // Output logic: winner selection. In DRAIN, any ALU result is a protocol
  // violation and is dropped.
  always_comb begin
    q_pop    = 1'b0;
    sel_vld  = 1'b0;
    sel_rd   = '0;
    sel_data = '0;
    if (state == DRAIN) begin
      q_pop    = !q_empty;
      sel_vld  = !q_empty;
      sel_rd   = head_rd;
      sel_data = head_data;
    end else if (alu_valid) begin
      sel_vld  = 1'b1;
      sel_rd   = alu_rd;
      sel_data = alu_data;
    end else if (!q_empty) begin
      q_pop    = 1'b1;
      sel_vld  = 1'b1;
      sel_rd   = head_rd;
      sel_data = head_data;
    end
  end

  // Registered write port. Writes to r0 are dropped; the queue entry is still consumed.
  always_ff @(posedge clk) begin
    if (rst) begin
      writeEnable <= 1'b0;
      waddr       <= '0;
      wdata       <= '0;
    end else begin
      writeEnable <= sel_vld && (sel_rd != '0);
      if (sel_vld) begin
        waddr <= sel_rd;
        wdata <= sel_data;
      end
    end
  end

  assign alu_hold = (state == DRAIN);

`ifdef WB_SCOREBOARD_EN
  logic [REG_COUNT-1:0] busy;

  // The set is written last, so it wins over a clear of the same register in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= '0;
    end else begin
      if (q_pop) busy[head_rd] <= 1'b0;
      if (iss_valid && (iss_rd != '0)) busy[iss_rd] <= 1'b1;
    end
  end

  assign q_busy = (q_rd != '0) && busy[q_rd];
`else
  logic unused_sb;
  assign unused_sb = ^{iss_valid, iss_rd, q_rd};
  assign q_busy    = 1'b0;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios followed by random traffic, checked each cycle
// against a queue-based reference model.
// Outputs are sampled 1 time unit after each rising edge.
module tb_wb_arbiter;
  import wb_pkg::*;

  localparam int RW  = 64;
  localparam int RC  = 32;
  localparam int LQD = 2;
  localparam int SL  = 4;
  localparam int IW  = 5;
`ifdef WB_SCOREBOARD_EN
  localparam bit SB = 1'b1;
`else
  localparam bit SB = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          alu_valid, ll_valid, iss_valid;
  logic [IW-1:0] alu_rd, ll_rd, iss_rd, q_rd;
  logic [RW-1:0] alu_data, ll_data;
  logic          alu_hold, ll_ready, q_busy, writeEnable;
  logic [IW-1:0] waddr;
  logic [RW-1:0] wdata;

  wb_arbiter #(
    .REG_WIDTH(RW), .REG_COUNT(RC), .LQ_DEPTH(LQD), .STARVE_LIMIT(SL)
  ) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_hold(alu_hold),
    .ll_valid(ll_valid), .ll_ready(ll_ready), .ll_rd(ll_rd), .ll_data(ll_data),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .q_rd(q_rd), .q_busy(q_busy),
    .writeEnable(writeEnable), .waddr(waddr), .wdata(wdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    reg_idx_t      rd;
    logic [RW-1:0] data;
  } ent_t;

  // Reference model state
  ent_t          mq[$];
  int            m_cnt  = 0;
  bit            m_hold = 1'b0;
  bit [RC-1:0]   m_busy = '0;
  bit            e_we   = 1'b0;
  bit            e_rstd = 1'b0;
  logic [IW-1:0] e_waddr = '0;
  logic [RW-1:0] e_wdata = '0;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drv(input bit av, input int ard, input logic [RW-1:0] ad,
                     input bit lv, input int lrd, input logic [RW-1:0] ld,
                     input bit iv, input int ird, input int qrd);
    alu_valid = av; alu_rd = IW'(ard); alu_data = ad;
    ll_valid  = lv; ll_rd  = IW'(lrd); ll_data  = ld;
    iss_valid = iv; iss_rd = IW'(ird); q_rd     = IW'(qrd);
  endtask

  // Advance one clock, update the model from the inputs seen at the edge, then check all outputs.
  task automatic tick();
    ent_t e;
    bit   pop, win_alu, full_pre;
    bit   exp_busy;
    @(posedge clk);
    pop = 1'b0; win_alu = 1'b0;
    full_pre = (mq.size() >= LQD);
    if (rst) begin
      mq.delete(); m_cnt = 0; m_hold = 1'b0; m_busy = '0;
      e_we = 1'b0; e_waddr = '0; e_wdata = '0; e_rstd = 1'b1;
    end else begin
      e_rstd = 1'b0;
      if (m_hold) begin
        pop = (mq.size() > 0); m_hold = 1'b0; m_cnt = 0;
      end else if (alu_valid) begin
        win_alu = 1'b1;
        if (mq.size() > 0) begin
          m_cnt++;
          if (m_cnt >= SL) m_hold = 1'b1;
        end else m_cnt = 0;
      end else begin
        pop = (mq.size() > 0); m_cnt = 0;
      end
      e_we = 1'b0;
      if (win_alu) begin
        e_we = (alu_rd != 0); e_waddr = alu_rd; e_wdata = alu_data;
      end else if (pop) begin
        e = mq.pop_front();
        e_we = (e.rd != 0); e_waddr = e.rd; e_wdata = e.data;
        m_busy[e.rd] = 1'b0;
      end
      if (iss_valid && iss_rd != 0) m_busy[iss_rd] = 1'b1;
      if (ll_valid && !full_pre) mq.push_back('{ll_rd, ll_data});
    end
    #1;
    exp_busy = SB && (q_rd != 0) && m_busy[q_rd];
    check("writeEnable", writeEnable, e_we);
    if (e_we || e_rstd) begin
      check("waddr", waddr, e_waddr);
      check("wdata", wdata, e_wdata);
    end
    check("alu_hold", alu_hold, m_hold);
    check("ll_ready", ll_ready, mq.size() < LQD);
    check("q_busy", q_busy, exp_busy);
  endtask

  initial begin
    // Reset state
    rst = 1'b1;
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick(); tick();
    check("rst_we", writeEnable, 0);
    check("rst_waddr", waddr, 0);
    check("rst_wdata", wdata, 0);
    check("rst_hold", alu_hold, 0);
    check("rst_ready", ll_ready, 1);
    rst = 1'b0;

    // Single ALU write
    drv(1, 5, 'hAA, 0, 0, 0, 0, 0, 0); tick();
    check("alu_we", writeEnable, 1);
    check("alu_waddr", waddr, 5);
    check("alu_wdata", wdata, 'hAA);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0); tick();

    // Two long-latency results with no ALU traffic drain on consecutive cycles
    drv(0, 0, 0, 1, 3, 'h33, 0, 0, 0); tick();
    drv(0, 0, 0, 1, 4, 'h44, 0, 0, 0); tick();
    check("ll3_we", writeEnable, 1);
    check("ll3_waddr", waddr, 3);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0); tick();
    check("ll4_waddr", waddr, 4);
    check("ll4_wdata", wdata, 'h44);
    tick();

    // ALU to r0 blocks pops and writes nothing; the queue fills
    drv(1, 0, 1, 1, 10, 'h10, 0, 0, 0); tick();
    drv(1, 0, 2, 1, 11, 'h11, 0, 0, 0); tick();
    check("r0_we", writeEnable, 0);
    check("full_ready", ll_ready, 0);
    drv(1, 0, 3, 1, 12, 'h12, 0, 0, 0); tick();

    // Reset with a full queue discards it
    rst = 1'b1; drv(0, 0, 0, 0, 0, 0, 0, 0, 0); tick();
    check("rstfull_ready", ll_ready, 1);
    rst = 1'b0; tick(); tick();
    check("rstfull_we", writeEnable, 0);

    // Starvation: rd7 queued, ALU held for STARVE_LIMIT wins
    drv(1, 1, 'h100, 1, 7, 'h77, 0, 0, 0); tick();
    for (int i = 0; i < SL; i++) begin
      drv(1, 1, RW'(i), 0, 0, 0, 0, 0, 0); tick();
    end
    check("starve_hold", alu_hold, 1);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0); tick();
    check("drain_waddr", waddr, 7);
    check("drain_wdata", wdata, 'h77);
    check("drain_hold_off", alu_hold, 0);

    // Scoreboard: set by issue, cleared by pop, set wins over same-cycle clear
    drv(0, 0, 0, 0, 0, 0, 1, 9, 9); tick();
    check("sb_set", q_busy, SB);
    drv(0, 0, 0, 1, 9, 'h99, 0, 0, 9); tick();
    check("sb_pending", q_busy, SB);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 9); tick();
    check("sb_clear", q_busy, 0);
    drv(0, 0, 0, 1, 9, 'h98, 1, 9, 9); tick();
    drv(0, 0, 0, 0, 0, 0, 1, 9, 9); tick();
    check("sb_setwins", q_busy, SB);
    drv(0, 0, 0, 1, 9, 'h97, 0, 0, 9); tick();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 9); tick();
    check("sb_clear2", q_busy, 0);

    // Random traffic against the model
    for (int c = 0; c < 600; c++) begin
      rst = ($urandom_range(0, 99) == 0);
      drv(($urandom_range(0, 2) != 0), $urandom_range(0, RC - 1), {$urandom, $urandom},
          $urandom_range(0, 1), $urandom_range(0, RC - 1), {$urandom, $urandom},
          ($urandom_range(0, 3) == 0), $urandom_range(0, RC - 1), $urandom_range(0, RC - 1));
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
